// File: rtl/fir_wb_axi_bridge_if.sv
// Bus bundle between the Wishbone-side decoder, the bridge and the FIR core.
// master = bridge view, slave = decoder + FIR view.
interface fir_wb_axi_bridge_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   fir_en;
    logic                   fir_we;
    logic [pADDR_WIDTH-1:0] fir_addr;
    logic [pDATA_WIDTH-1:0] fir_dat_i;
    logic                   fir_valid;
    logic [pDATA_WIDTH-1:0] fir_dat_o;

    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;

    modport master (
        input  fir_en, fir_we, fir_addr, fir_dat_i,
        output fir_valid, fir_dat_o,
        output awvalid, awaddr, wvalid, wdata,
        input  awready, wready,
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata,
        output ss_tvalid, ss_tdata, ss_tlast,
        input  ss_tready,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready
    );

    modport slave (
        output fir_en, fir_we, fir_addr, fir_dat_i,
        input  fir_valid, fir_dat_o,
        input  awvalid, awaddr, wvalid, wdata,
        output awready, wready,
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata,
        input  ss_tvalid, ss_tdata, ss_tlast,
        output ss_tready,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready
    );
endinterface

// File: rtl/fir_wb_axi_bridge.sv
// Wishbone-to-AXI-Lite/AXI-Stream bridge for the FIR window, one access -> one AXI transaction.
// Optional FIR_BRIDGE_TLAST_EN: ss_tlast generated from a shadowed data_length register.
module fir_wb_axi_bridge #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    fir_wb_axi_bridge_if.master bus
);
    localparam logic [pADDR_WIDTH-1:0] ADDR_SS  = pADDR_WIDTH'('h80);
    localparam logic [pADDR_WIDTH-1:0] ADDR_SM  = pADDR_WIDTH'('h84);

    typedef enum logic [2:0] {
        IDLE,
        LWR,
        LRA,
        LRD,
        SS,
        SM,
        DONE
    } state_e;

    state_e                 state_q;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [pDATA_WIDTH-1:0] wdat_q;
    logic [pDATA_WIDTH-1:0] rdat_q;
    logic                   ack_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   arvalid_q;
    logic                   rready_q;
    logic                   ss_tvalid_q;
    logic                   sm_tready_q;

    logic hit_lite;
    logic hit_ss;
    logic hit_sm;
    logic aw_ok;
    logic w_ok;

    assign hit_lite = bus.fir_addr[pADDR_WIDTH-1:7] == '0;
    assign hit_ss   = bus.fir_addr == ADDR_SS;
    assign hit_sm   = bus.fir_addr == ADDR_SM;

    // Each Lite write channel is finished once its valid has been consumed.
    assign aw_ok = !awvalid_q || bus.awready;
    assign w_ok  = !wvalid_q || bus.wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            ack_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ss_tvalid_q <= 1'b0;
            sm_tready_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.fir_en) begin
                        addr_q <= bus.fir_addr;
                        wdat_q <= bus.fir_dat_i;
                        unique case (1'b1)
                            hit_lite && bus.fir_we: begin
                                state_q   <= LWR;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                            end
                            hit_lite && !bus.fir_we: begin
                                state_q   <= LRA;
                                arvalid_q <= 1'b1;
                            end
                            hit_ss && bus.fir_we: begin
                                state_q     <= SS;
                                ss_tvalid_q <= 1'b1;
                            end
                            hit_sm && !bus.fir_we: begin
                                state_q     <= SM;
                                sm_tready_q <= 1'b1;
                            end
                            default: begin
                                state_q <= DONE;
                                ack_q   <= 1'b1;
                                if (!bus.fir_we) rdat_q <= '0;
                            end
                        endcase
                    end
                end
                LWR: begin
                    if (bus.awready) awvalid_q <= 1'b0;
                    if (bus.wready) wvalid_q <= 1'b0;
                    if (aw_ok && w_ok) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end
                end
                LRA: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= LRD;
                    end
                end
                LRD: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        rdat_q   <= bus.rdata;
                        state_q  <= DONE;
                        ack_q    <= 1'b1;
                    end
                end
                SS: begin
                    if (bus.ss_tready) begin
                        ss_tvalid_q <= 1'b0;
                        state_q     <= DONE;
                        ack_q       <= 1'b1;
                    end
                end
                SM: begin
                    if (bus.sm_tvalid) begin
                        sm_tready_q <= 1'b0;
                        rdat_q      <= bus.sm_tdata;
                        state_q     <= DONE;
                        ack_q       <= 1'b1;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fir_valid = ack_q;
    assign bus.fir_dat_o = rdat_q;
    assign bus.awvalid   = awvalid_q;
    assign bus.awaddr    = addr_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wdat_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = addr_q;
    assign bus.rready    = rready_q;
    assign bus.ss_tvalid = ss_tvalid_q;
    assign bus.ss_tdata  = wdat_q;
    assign bus.sm_tready = sm_tready_q;

`ifdef FIR_BRIDGE_TLAST_EN
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN = pADDR_WIDTH'('h10);

    logic [pDATA_WIDTH-1:0] len_q;
    logic [pDATA_WIDTH-1:0] cnt_q;
    logic [pDATA_WIDTH-1:0] cnt_d;
    logic                   lwr_done;
    logic                   ss_hs;
    logic                   last_hit;

    assign lwr_done = (state_q == LWR) && aw_ok && w_ok;
    assign ss_hs    = ss_tvalid_q && bus.ss_tready;
    // Zero length never matches, so tlast stays low.
    assign last_hit = (len_q != '0) && (cnt_q == len_q - 1'b1);

    always_comb begin
        cnt_d = cnt_q;
        if (lwr_done && addr_q == ADDR_CTL && wdat_q[0]) begin
            cnt_d = '0;
        end else if (ss_hs) begin
            cnt_d = last_hit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (lwr_done && addr_q == ADDR_LEN) len_q <= wdat_q;
        end
    end

    assign bus.ss_tlast = ss_tvalid_q && last_hit;
`else
    assign bus.ss_tlast = 1'b0;
`endif
endmodule

// File: doc/fir_wb_axi_bridge.md
# fir_wb_axi_bridge

Converts the user project's decoded Wishbone accesses in the 0x30xx_xxxx window into AXI4-Lite and AXI4-Stream transactions toward the FIR engine. It sits between the user-project Wishbone address decoder and the FIR core: configuration registers and taps use AXI-Lite, and input/output samples use the stream ports. One Wishbone access maps to exactly one AXI transaction, acknowledged with a single-cycle `fir_valid` pulse.

## Interface
- pADDR_WIDTH, 12: AXI-Lite address width; equals width of `fir_addr`.
- pDATA_WIDTH, 32: data width of all buses.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- fir_en  in  1  decoded Wishbone request (cyc & stb & address hit); held high until `fir_valid`.
- fir_we  in  1  1 = write, 0 = read; qualified by `fir_en`.
- fir_addr  in  pADDR_WIDTH  byte offset within the FIR window.
- fir_dat_i  in  pDATA_WIDTH  write data.
- fir_valid  out  1  one-cycle acknowledge.
- fir_dat_o  out  pDATA_WIDTH  read data; holds its value until the next read completes.
- awvalid, awready, awaddr  out/in/out  1/1/pADDR_WIDTH  AXI-Lite write-address channel.
- wvalid, wready, wdata  out/in/out  1/1/pDATA_WIDTH  AXI-Lite write-data channel.
- arvalid, arready, araddr  out/in/out  1/1/pADDR_WIDTH  AXI-Lite read-address channel.
- rvalid, rready, rdata  in/out/in  1/1/pDATA_WIDTH  AXI-Lite read-data channel.
- ss_tvalid, ss_tready, ss_tdata, ss_tlast  out/in/out/out  1/1/pDATA_WIDTH/1  input sample stream to the FIR.
- sm_tvalid, sm_tready, sm_tdata, sm_tlast  in/out/in/in  1/1/pDATA_WIDTH/1  output sample stream from the FIR; `sm_tlast` is ignored.

## Operation
- Address map (`fir_addr`):
  - 0x000–0x07F: AXI-Lite. Covers 0x00 ap_ctrl, 0x10 data_length, and 0x40–0x7F taps.
  - 0x080 write: ss push.
  - 0x084 read: sm pop.
  - Anything else: "null" access.
- FSM states: IDLE, LWR, LRA, LRD, SS, SM, DONE.
- IDLE → (fir_en) transition:
  - On the clock edge where `fir_en` = 1, capture `fir_addr`, `fir_dat_i` and `fir_we`.
  - Go to LWR for a Lite write, LRA for a Lite read, SS for a write to 0x080, SM for a read from 0x084.
  - Go to DONE for a null access, a read of 0x080, or a write to 0x084.
- LWR:
  - `awvalid` and `wvalid` rise together.
  - Each drops on the cycle after its own ready handshake.
  - Go to DONE once both handshakes have occurred, in either order or in the same cycle.
- LRA: hold `arvalid` until `arready`, then go to LRD.
- LRD: hold `rready` = 1 until `rvalid`; capture `rdata` into `fir_dat_o`, then go to DONE.
- SS: hold `ss_tvalid` with `ss_tdata` = captured data until `ss_tready`, then go to DONE.
- SM: hold `sm_tready` = 1 until `sm_tvalid`; capture `sm_tdata` into `fir_dat_o`, then go to DONE.
- DONE: `fir_valid` = 1 for exactly one cycle, then return to IDLE. `fir_en` is not sampled in DONE.
- Null reads return 0 in `fir_dat_o`. Null writes are discarded.
- All valid/ready outputs are registered. Payload outputs (addr/data) are stable for as long as the corresponding valid is high.
- Reset values: all valid/ready outputs 0, `fir_valid` 0, `fir_dat_o` 0, `ss_tlast` 0, FSM in IDLE, captured registers 0.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously), the transaction is dropped, and no ack is issued.

## Timing
- Request accepted at edge T0. AXI valid or stream ready is asserted from T0 until the handshake edge.
- With zero-wait slaves, `fir_valid` is high in cycle T0+2 for Lite write, SS and SM; T0+3 for Lite read; T0+1 for a null access.
- Back-to-back: a new `fir_en` is accepted at the earliest one cycle after `fir_valid`.
- `fir_dat_o` becomes valid in the same cycle as `fir_valid`.

## Configuration
- FIR_BRIDGE_TLAST_EN defined:
  - The bridge shadows every completed Lite write to 0x10 into a 32-bit length register.
  - A 32-bit sample counter counts ss handshakes.
  - `ss_tlast` = 1 on the push where counter == length-1. After that handshake the counter clears.
  - The counter also clears on a completed Lite write to 0x00 with data bit0 = 1.
  - Length 0: `ss_tlast` is never asserted.
- FIR_BRIDGE_TLAST_EN undefined: `ss_tlast` is tied to 0, and no length register or counter is present.

## Test plan
- Lite write to 0x40, data 0x0000_0005, awready delayed 3 cycles, wready immediate → awaddr = 0x40 and wdata = 5 are each seen exactly once; one `fir_valid` pulse.
- Lite read of 0x00, arready immediate, rvalid after 2 cycles with rdata 0x0000_0004 → `fir_dat_o` = 0x4 in the `fir_valid` cycle.
- Push 0x0000_0007 to 0x080 with ss_tready low for 5 cycles → `ss_tvalid` and data held stable throughout; ack one cycle after the ready handshake.
- Pop from 0x084 with sm_tvalid arriving after 4 cycles carrying 0xFFFF_FFFE → `fir_dat_o` = 0xFFFF_FFFE; `sm_tready` drops after the handshake.
- Read 0x100 → `fir_valid` at T0+1, `fir_dat_o` = 0, no AXI activity. Then assert rst_n low during a stalled SS push → `ss_tvalid` = 0 immediately and no ack is issued.
- With FIR_BRIDGE_TLAST_EN: write 3 to 0x10, then push 4 samples → `ss_tlast` = 1 on the 3rd push only, and 0 on the 4th.
